piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out shifter; next generation of the datapath's fixed 10-bit P-to-S shifter.
- Adds configurable width and bit order, a valid/ready load handshake, per-bit shift enable (stall), a bit counter and an end-of-word pulse.
- Sits between the datapath's word sources and serial links or bit-serial ALU stages.
- Supports back-to-back words with no idle bubble.

---
 rtl/piso_serializer.sv | 78 +++++++
 tb/tb_piso_serializer.sv | 114 +++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parametrised parallel-in/serial-out shifter with load handshake, stall, bit counter and done pulse; define PISO_PARITY_EN to append an even-parity bit to each frame
module piso_serializer #(
  parameter int WIDTH     = 10,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                          Clock,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              data,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic                          shift_en,
  input  logic                          sIn,
  output logic                          sOut,
  output logic                          sOut_valid,
  output logic                          busy,
  output logic [$clog2(WIDTH+2)-1:0]    bit_cnt,
  output logic                          done
);
  localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt_n;
  logic             last, load, head;
  assign busy       = state == SHIFT;
  assign sOut_valid = busy;
  assign last       = busy && bit_cnt == CW'(1) && shift_en;
  assign load_ready = !busy || last;
  assign load       = load_valid && load_ready;
  assign head       = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
  logic par;
  assign sOut = busy && (bit_cnt == CW'(1) ? par : head);
  // latch even parity of each accepted word; it is sent once the data bits are exhausted
  always_ff @(posedge Clock) begin
    if (rst) par <= 1'b0;
    else if (load) par <= ^data;
  end
`else
  assign sOut = busy && head;
`endif
  // next state: a load (including the back-to-back case) beats finishing, which beats shifting
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = bit_cnt;
    if (load) begin
      state_n = SHIFT;
      shreg_n = data;
      cnt_n   = CW'(FRAME);
    end else if (last) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (busy && shift_en) begin
      shreg_n = LSB_FIRST ? {sIn, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], sIn};
      cnt_n   = bit_cnt - CW'(1);
    end
  end
  // state register; done is the registered last-bit strobe so it lands one cycle after consumption
  always_ff @(posedge Clock) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= cnt_n;
      done    <= last;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table-driven bench for piso_serializer, MSB-first and LSB-first instances on shared stimulus
module tb_piso_serializer;
  localparam int W = 10;
`ifdef PISO_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif
  localparam logic [W-1:0] WA = 10'b1000010100;
  localparam logic [W-1:0] WB = 10'b0000000001;
  logic Clock = 1'b0, rst = 1'b1, load_valid = 1'b0, shift_en = 1'b0, sIn = 1'b1;
  logic [W-1:0] data = '0;
  logic load_ready, sOut, sOut_valid, busy, done;
  logic [3:0] bit_cnt;
  logic lr2, so2, sv2, b2, d2;
  logic [3:0] bc2;
  int checks = 0, failures = 0;
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut (
    .Clock(Clock), .rst(rst), .data(data), .load_valid(load_valid), .load_ready(load_ready),
    .shift_en(shift_en), .sIn(sIn), .sOut(sOut), .sOut_valid(sOut_valid), .busy(busy),
    .bit_cnt(bit_cnt), .done(done));
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .Clock(Clock), .rst(rst), .data(data), .load_valid(load_valid), .load_ready(lr2),
    .shift_en(shift_en), .sIn(sIn), .sOut(so2), .sOut_valid(sv2), .busy(b2),
    .bit_cnt(bc2), .done(d2));
  always #5 Clock = ~Clock;
  typedef struct {
    logic r, lv;
    logic [W-1:0] d;
    logic se, so, sl, v;
    logic [3:0] c;
    logic dn, rd;
  } vec_t;
  vec_t q[$];
  function automatic void add(logic r, logic lv, logic [W-1:0] d, logic se, logic so, logic sl,
                              logic v, logic [3:0] c, logic dn, logic rd);
    vec_t t;
    t.r = r; t.lv = lv; t.d = d; t.se = se; t.so = so; t.sl = sl;
    t.v = v; t.c = c; t.dn = dn; t.rd = rd;
    q.push_back(t);
  endfunction
  function automatic logic bm(logic [W-1:0] w, int i);
    return i < W ? w[W-1-i] : ^w;
  endfunction
  function automatic logic bl(logic [W-1:0] w, int i);
    return i < W ? w[i] : ^w;
  endfunction
  function automatic void bit_v(logic [W-1:0] w, int i);
    add(0, 0, '0, 1, bm(w, i), bl(w, i), 1, 4'(F - i), 0, i == F - 1);
  endfunction
  function automatic void idle_v(logic dn);
    add(0, 0, '0, 1, 0, 0, 0, 4'd0, dn, 1);
  endfunction
  task automatic chk(string n, int k, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", n, k, a, e);
    end
  endtask
  initial begin
    // A: plain word, shift_en held high
    add(0, 1, WA, 1, 0, 0, 0, 4'd0, 0, 1);
    for (int i = 0; i < F; i++) bit_v(WA, i);
    idle_v(1);
    idle_v(0);
    // B: three-cycle stall after the 4th bit; a load attempt during the stall is ignored
    add(0, 1, WA, 1, 0, 0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 4; i++) bit_v(WA, i);
    for (int k = 0; k < 3; k++) add(0, 1, '1, 0, bm(WA, 4), bl(WA, 4), 1, 4'(F - 4), 0, 0);
    for (int i = 4; i < F; i++) bit_v(WA, i);
    idle_v(1);
    idle_v(0);
    // C: back-to-back, second word offered during the last bit of the first
    add(0, 1, WA, 1, 0, 0, 0, 4'd0, 0, 1);
    for (int i = 0; i < F - 1; i++) bit_v(WA, i);
    add(0, 1, WB, 1, bm(WA, F - 1), bl(WA, F - 1), 1, 4'd1, 0, 1);
    for (int i = 0; i < F; i++)
      add(0, 0, '0, 1, bm(WB, i), bl(WB, i), 1, 4'(F - i), i == 0, i == F - 1);
    idle_v(1);
    idle_v(0);
    // D: reset mid-word at bit_cnt=5 with a load offered, then reset in IDLE with a load offered
    add(0, 1, WA, 1, 0, 0, 0, 4'd0, 0, 1);
    for (int i = 0; i < F - 5; i++) bit_v(WA, i);
    add(1, 1, WB, 1, bm(WA, F - 5), bl(WA, F - 5), 1, 4'd5, 0, 0);
    idle_v(0);
    add(1, 1, WB, 1, 0, 0, 0, 4'd0, 0, 1);
    idle_v(0);
    idle_v(0);
    rst = 1'b1;
    @(posedge Clock);
    #1;
    foreach (q[k]) begin
      rst = q[k].r;
      load_valid = q[k].lv;
      data = q[k].d;
      shift_en = q[k].se;
      sIn = 1'b1;
      #1;
      chk("sOut", k, 32'(sOut), 32'(q[k].so));
      chk("sOut_lsb", k, 32'(so2), 32'(q[k].sl));
      chk("sOut_valid", k, 32'(sOut_valid), 32'(q[k].v));
      chk("busy", k, 32'(busy), 32'(q[k].v));
      chk("sOut_valid_lsb", k, 32'(sv2), 32'(q[k].v));
      chk("bit_cnt", k, 32'(bit_cnt), 32'(q[k].c));
      chk("done", k, 32'(done), 32'(q[k].dn));
      chk("load_ready", k, 32'(load_ready), 32'(q[k].rd));
      @(posedge Clock);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
